// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, legal-opcode check and response-register state
// shared by the ALU arbiter slice. Rev 1.0
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLTU, ALU_SRL, ALU_SLL, ALU_SRA: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// alu: 32-bit combinational ALU; illegal opcodes produce a zero result.
// Rev 1.0
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: result = {31'b0, src_a < src_b};
      ALU_SLL:  result = src_a << shamt;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      default:  result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU behind a single response register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins). Rev 1.0
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src_a,
  input  logic [31:0]      req0_src_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src_a,
  input  logic [31:0]      req1_src_b,
  input  logic [3:0]       req1_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  rsp_state_t state, state_next;
  logic       sel;
  logic       can_grant;
  logic       grant;
  logic [31:0] op_a, op_b, alu_result;
  logic [3:0]  op_ctrl;
  logic [TAG_W-1:0] op_tag;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign sel = ~req0_valid;
`else
  logic last_grant;

  // Reset to port 1 so port 0 wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (reset)      last_grant <= 1'b1;
    else if (grant) last_grant <= sel;
  end

  assign sel = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;
`endif

  assign can_grant  = ~reset & ((state == RSP_EMPTY) | rsp_ready);
  assign grant      = can_grant & (req0_valid | req1_valid);
  assign req0_ready = grant & ~sel;
  assign req1_ready = grant & sel;

  assign op_a    = sel ? req1_src_a : req0_src_a;
  assign op_b    = sel ? req1_src_b : req0_src_b;
  assign op_ctrl = sel ? req1_ctrl  : req0_ctrl;
  assign op_tag  = sel ? req1_tag   : req0_tag;

  alu u_alu (
    .src_a  (op_a),
    .src_b  (op_b),
    .ctrl   (op_ctrl),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RSP_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RSP_EMPTY: if (grant)              state_next = RSP_FULL;
      RSP_FULL:  if (rsp_ready & ~grant) state_next = RSP_EMPTY;
      default:                           state_next = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (grant) begin
      rsp_id     <= sel;
      rsp_tag    <= op_tag;
      rsp_result <= alu_result;
      rsp_zero   <= (alu_result == 32'd0);
      rsp_err    <= ~is_legal_op(op_ctrl);
    end
  end

  assign rsp_valid = (state == RSP_FULL);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_src_a = '0, req0_src_b = '0, req1_src_a = '0, req1_src_b = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_src_a (req0_src_a),
    .req0_src_b (req0_src_b),
    .req0_ctrl  (req0_ctrl),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_src_a (req1_src_a),
    .req1_src_b (req1_src_b),
    .req1_ctrl  (req1_ctrl),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
    req0_valid = v; req0_ctrl = c; req0_src_a = a; req0_src_b = b; req0_tag = t;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
    req1_valid = v; req1_ctrl = c; req1_src_a = a; req1_src_b = b; req1_tag = t;
  endtask

  initial begin
    logic [3:0] exp_id [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = '{4'd0, 4'd0, 4'd0, 4'd0};
`else
    exp_id = '{4'd0, 4'd1, 4'd0, 4'd1};
`endif

    // Reset: outputs cleared, no ready while reset is high even with a request pending.
    set_req0(1'b1, 4'b0000, 32'd1, 32'd1, 4'd1);
    tick(); tick();
    check("reset_rsp_valid",  {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_id",     {31'b0, rsp_id},    32'd0);
    check("reset_rsp_tag",    {28'b0, rsp_tag},   32'd0);
    check("reset_rsp_result", rsp_result,         32'd0);
    check("reset_rsp_zero",   {31'b0, rsp_zero},  32'd0);
    check("reset_rsp_err",    {31'b0, rsp_err},   32'd0);
    check("reset_req0_ready", {31'b0, req0_ready}, 32'd0);

    // Contention straight out of reset: port 0 add 1+2, port 1 and 0xFF&0x0F.
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req0(1'b1, 4'b0000, 32'd1, 32'd2, 4'd1);
    set_req1(1'b1, 4'b0100, 32'h0000_00FF, 32'h0000_000F, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_ready0_%0d", i), {31'b0, req0_ready}, {31'b0, exp_id[i] == 4'd0});
      check($sformatf("rr_ready1_%0d", i), {31'b0, req1_ready}, {31'b0, exp_id[i] == 4'd1});
      tick();
      check($sformatf("rr_rsp_id_%0d", i), {31'b0, rsp_id}, {28'b0, exp_id[i]});
      check($sformatf("rr_rsp_result_%0d", i), rsp_result,
            (exp_id[i] == 4'd0) ? 32'd3 : 32'h0000_000F);
    end
    set_req0(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
    set_req1(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
    tick();
    check("drain_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Lone port 0: add 5+7 tag 3.
    set_req0(1'b1, 4'b0000, 32'd5, 32'd7, 4'd3);
    #1;
    check("add_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    set_req0(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
    check("add_rsp_valid",  {31'b0, rsp_valid}, 32'd1);
    check("add_rsp_result", rsp_result,         32'd12);
    check("add_rsp_id",     {31'b0, rsp_id},    32'd0);
    check("add_rsp_tag",    {28'b0, rsp_tag},   32'd3);
    check("add_rsp_zero",   {31'b0, rsp_zero},  32'd0);
    tick();
    check("add_drain_valid", {31'b0, rsp_valid}, 32'd0);

    // Port 1 sub 9-9 with consumer stalled; port 0 waits for the drain cycle.
    rsp_ready = 1'b0;
    set_req1(1'b1, 4'b0001, 32'd9, 32'd9, 4'd7);
    #1;
    check("sub_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    set_req1(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
    set_req0(1'b1, 4'b0101, 32'h0000_00F0, 32'h0000_000F, 4'd5);
    check("sub_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sub_rsp_id",    {31'b0, rsp_id},    32'd1);
    check("sub_rsp_tag",   {28'b0, rsp_tag},   32'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_req0_ready_%0d", i), {31'b0, req0_ready}, 32'd0);
      tick();
      check($sformatf("stall_valid_%0d", i),  {31'b0, rsp_valid}, 32'd1);
      check($sformatf("stall_result_%0d", i), rsp_result,         32'd0);
      check($sformatf("stall_zero_%0d", i),   {31'b0, rsp_zero},  32'd1);
      check($sformatf("stall_tag_%0d", i),    {28'b0, rsp_tag},   32'd7);
    end
    rsp_ready = 1'b1;
    #1;
    check("drain_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    check("or_rsp_result", rsp_result,       32'h0000_00FF);
    check("or_rsp_id",     {31'b0, rsp_id},  32'd0);
    check("or_rsp_tag",    {28'b0, rsp_tag}, 32'd5);

    // Illegal opcode 0011, issued back-to-back while FULL with rsp_ready=1.
    set_req0(1'b1, 4'b0011, 32'd5, 32'd7, 4'd2);
    #1;
    check("illegal_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    check("illegal_rsp_err",    {31'b0, rsp_err},  32'd1);
    check("illegal_rsp_result", rsp_result,        32'd0);
    check("illegal_rsp_zero",   {31'b0, rsp_zero}, 32'd1);

    // Shifts and compares.
    set_req0(1'b1, 4'b1111, 32'h8000_0000, 32'd4, 4'd4);
    tick();
    check("sra_result", rsp_result,       32'hF800_0000);
    check("sra_err",    {31'b0, rsp_err}, 32'd0);
    set_req0(1'b1, 4'b1001, 32'd1, 32'hFFFF_FFFF, 4'd6);
    tick();
    check("sltu_result", rsp_result, 32'd1);
    set_req0(1'b1, 4'b1000, 32'd1, 32'hFFFF_FFFF, 4'd6);
    tick();
    check("slt_result", rsp_result, 32'd0);
    set_req0(1'b1, 4'b1110, 32'h0000_0003, 32'h0000_0021, 4'd8);
    tick();
    check("sll_result", rsp_result, 32'h0000_0006);
    set_req0(1'b1, 4'b1101, 32'h8000_0000, 32'd4, 4'd9);
    tick();
    check("srl_result", rsp_result, 32'h0800_0000);

    // Reset while FULL discards the response; port 0 wins first after release.
    set_req0(1'b0, 4'b0000, 32'd0, 32'd0, 4'd0);
    rsp_ready = 1'b0;
    tick();
    check("pre_reset_valid", {31'b0, rsp_valid}, 32'd1);
    reset = 1'b1;
    set_req0(1'b1, 4'b0110, 32'h0000_00FF, 32'h0000_0F0F, 4'd10);
    set_req1(1'b1, 4'b0000, 32'd2, 32'd2, 4'd11);
    rsp_ready = 1'b1;
    #1;
    check("reset_hi_ready0", {31'b0, req0_ready}, 32'd0);
    check("reset_hi_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    check("reset_mid_valid", {31'b0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_ready0", {31'b0, req0_ready}, 32'd1);
    check("post_reset_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    check("post_reset_id",     {31'b0, rsp_id},  32'd0);
    check("post_reset_result", rsp_result,       32'h0000_0FF0);
    check("post_reset_tag",    {28'b0, rsp_tag}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
